// File: rtl/share_feeder_pkg.sv
// Shared definitions for masked-gadget share controllers: FSM states, the
// mask LFSR polynomial/reset value and the default AND-stage timeout.
package share_feeder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } sf_state_e;

   localparam int unsigned SF_LFSR_W       = 16;
   // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form taps bits 0,2,3,5
   localparam logic [15:0] SF_LFSR_TAPS    = 16'h002D;
   localparam logic [15:0] SF_LFSR_RST     = 16'hACE1;
   localparam int unsigned SF_TIMEOUT_DFLT = 8;

   function automatic logic [15:0] lfsr_next(input logic [15:0] q);
      return {^(q & SF_LFSR_TAPS), q[15:1]};
   endfunction

endpackage

// File: rtl/share_feeder_if.sv
// Operand, share and result signals between upstream, share_feeder and the
// masked AND stage; master is the feeder, slave is its environment.
interface share_feeder_if;

   logic        seed_load;
   logic [15:0] seed;
   logic        in_valid;
   logic        in_ready;
   logic        a_in;
   logic        b_in;
   logic [1:0]  ina;
   logic [1:0]  inb;
   logic        rin;
   logic        and_enable;
   logic        and_done;
   logic [1:0]  and_out;
   logic        res;
   logic        res_valid;
   logic        err_timeout;

   modport master (
      input  seed_load, seed, in_valid, a_in, b_in, and_done, and_out,
      output in_ready, ina, inb, rin, and_enable, res, res_valid, err_timeout
   );

   modport slave (
      output seed_load, seed, in_valid, a_in, b_in, and_done, and_out,
      input  in_ready, ina, inb, rin, and_enable, res, res_valid, err_timeout
   );

endinterface

// File: rtl/mask_lfsr.sv
// Free-running 16-bit Fibonacci LFSR supplying mask/refresh bits; a seed load
// overrides stepping, and an all-zero seed is replaced by 1 to avoid lock-up.
module mask_lfsr
   import share_feeder_pkg::*;
#(
   parameter int unsigned W   = SF_LFSR_W,
   parameter int unsigned Q_W = SF_LFSR_W
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           load,
   input  logic [W-1:0]   seed,
   output logic [Q_W-1:0] q
);

   logic [W-1:0] r_lfsr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr <= SF_LFSR_RST;
      end else if (load) begin
         r_lfsr <= (seed == '0) ? W'(1) : seed;
      end else begin
         r_lfsr <= lfsr_next(r_lfsr);
      end
   end

   assign q = r_lfsr[Q_W-1:0];

endmodule

// File: rtl/share_feeder.sv
// Splits two unmasked bits into Boolean shares, drives a masked AND stage,
// unmasks its output shares and flags a stage that never reports done.
module share_feeder
   import share_feeder_pkg::*;
#(
   parameter int unsigned LFSR_W  = SF_LFSR_W,
   parameter int unsigned TIMEOUT = SF_TIMEOUT_DFLT
) (
   input  logic clk,
   input  logic rst_n,
   share_feeder_if.master bus
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   sf_state_e        r_state;
   logic             r_in_ready;
   logic             r_a;
   logic             r_b;
   logic [1:0]       r_ina;
   logic [1:0]       r_inb;
   logic             r_rin;
   logic             r_and_en;
   logic [1:0]       r_and_out;
   logic             r_res_valid;
   logic             r_err;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       w_mask;
   logic             w_accept;

   mask_lfsr #(
      .W   (LFSR_W),
      .Q_W (3)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (bus.seed_load),
      .seed  (bus.seed),
      .q     (w_mask)
   );

   // in_ready is registered so it stays low through reset and rises one edge later
   assign w_accept = r_in_ready & bus.in_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_in_ready  <= 1'b0;
         r_a         <= 1'b0;
         r_b         <= 1'b0;
         r_ina       <= '0;
         r_inb       <= '0;
         r_rin       <= 1'b0;
         r_and_en    <= 1'b0;
         r_and_out   <= '0;
         r_res_valid <= 1'b0;
         r_err       <= 1'b0;
         r_cnt       <= '0;
      end else begin
         r_res_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_a        <= bus.a_in;
                  r_b        <= bus.b_in;
                  r_in_ready <= 1'b0;
                  r_state    <= LOAD;
               end else begin
                  r_in_ready <= 1'b1;
               end
            end
            LOAD: begin
               // share index 0 carries the masked value, index 1 the mask itself
               r_ina    <= {w_mask[0], r_a ^ w_mask[0]};
               r_inb    <= {w_mask[1], r_b ^ w_mask[1]};
               r_rin    <= w_mask[2];
               r_and_en <= 1'b1;
               r_cnt    <= '0;
               r_state  <= RUN;
            end
            RUN: begin
               if (bus.and_done) begin
                  r_and_out   <= bus.and_out;
                  r_res_valid <= 1'b1;
                  r_and_en    <= 1'b0;
                  r_state     <= DONE;
               end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                  r_err      <= 1'b1;
                  r_and_en   <= 1'b0;
                  r_ina      <= '0;
                  r_inb      <= '0;
                  r_rin      <= 1'b0;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b1;
                  r_state    <= IDLE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            DONE: begin
               r_ina      <= '0;
               r_inb      <= '0;
               r_rin      <= 1'b0;
               r_cnt      <= '0;
               r_in_ready <= 1'b1;
               r_state    <= IDLE;
            end
            default: begin
               r_in_ready <= 1'b0;
               r_state    <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready    = r_in_ready;
   assign bus.ina         = r_ina;
   assign bus.inb         = r_inb;
   assign bus.rin         = r_rin;
   assign bus.and_enable  = r_and_en;
   assign bus.res         = ^r_and_out;
   assign bus.res_valid   = r_res_valid;
   assign bus.err_timeout = r_err;

endmodule

// File: tb/tb_share_feeder.sv
// Directed bench for share_feeder with a behavioural masked-AND responder.
module tb_share_feeder;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   share_feeder_if sif ();

   share_feeder #(
      .LFSR_W  (16),
      .TIMEOUT (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sif)
   );

   int checks = 0;
   int errors = 0;

   int   done_lat  = 0;
   int   run_cnt   = 0;
   logic spur_done = 1'b0;

   // AND stage: done after done_lat enabled cycles (0 = never), shares of a&b
   always @(negedge clk) begin
      if (sif.and_enable === 1'b1) begin
         run_cnt = run_cnt + 1;
         if (done_lat != 0 && run_cnt >= done_lat) begin
            sif.and_done = 1'b1;
            sif.and_out  = {((sif.ina[0] ^ sif.ina[1]) & (sif.inb[0] ^ sif.inb[1])) ^ sif.rin, sif.rin};
         end else begin
            sif.and_done = 1'b0;
            sif.and_out  = 2'b00;
         end
      end else begin
         run_cnt      = 0;
         sif.and_done = spur_done;
         sif.and_out  = 2'b01;
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic run_txn(input bit a, input bit b, input int lat, input bit keep,
                          output int n_valid, output bit r, output int share_bad,
                          output int hold_bad, output int n_run, output int lat_cyc,
                          output logic [1:0] s_ina, output logic [1:0] s_inb,
                          output logic s_rin, output bit hung);
      int w;
      int c;
      n_valid = 0; r = 1'b0; share_bad = 0; hold_bad = 0; n_run = 0; lat_cyc = 0;
      s_ina = 2'b00; s_inb = 2'b00; s_rin = 1'b0; hung = 1'b0;
      done_lat = lat;
      sif.a_in = a; sif.b_in = b; sif.in_valid = 1'b1;
      w = 0;
      while (sif.in_ready !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (sif.in_ready !== 1'b1) begin
         sif.in_valid = 1'b0;
         hung = 1'b1;
         return;
      end
      @(negedge clk);
      if (!keep) sif.in_valid = 1'b0;
      c = 1;
      forever begin
         if (sif.and_enable === 1'b1) begin
            if (n_run == 0) begin
               s_ina = sif.ina; s_inb = sif.inb; s_rin = sif.rin;
            end else if (sif.ina !== s_ina || sif.inb !== s_inb || sif.rin !== s_rin) begin
               hold_bad++;
            end
            if ((sif.ina[0] ^ sif.ina[1]) !== a || (sif.inb[0] ^ sif.inb[1]) !== b) share_bad++;
            n_run++;
         end
         if (sif.res_valid === 1'b1) begin
            n_valid++;
            r = sif.res;
            lat_cyc = c + 1;
         end
         if (sif.in_ready === 1'b1) begin
            if (sif.ina !== 2'b00 || sif.inb !== 2'b00 || sif.rin !== 1'b0) share_bad++;
            break;
         end
         if (c >= 40) begin
            hung = 1'b1;
            break;
         end
         @(negedge clk);
         c++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      sif.seed_load = 1'b0; sif.seed = 16'h0000;
      sif.in_valid = 1'b0; sif.a_in = 1'b0; sif.b_in = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (sif.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", sif.in_ready); end
      checks++;
      if (sif.and_enable !== 1'b0 || sif.res_valid !== 1'b0 || sif.err_timeout !== 1'b0 || sif.res !== 1'b0) begin
         errors++;
         $display("FAIL rst_ctrl: en=%b rv=%b err=%b res=%b want all 0", sif.and_enable, sif.res_valid, sif.err_timeout, sif.res);
      end
      checks++;
      if (sif.ina !== 2'b00 || sif.inb !== 2'b00 || sif.rin !== 1'b0) begin
         errors++;
         $display("FAIL rst_shares: ina=%b inb=%b rin=%b want 0", sif.ina, sif.inb, sif.rin);
      end
      checks++;
      if (dut.u_lfsr.r_lfsr !== 16'hACE1) begin errors++; $display("FAIL rst_lfsr: got %h want ace1", dut.u_lfsr.r_lfsr); end
      rst_n = 1'b1;
      #1;
      checks++;
      if (sif.in_ready !== 1'b0) begin errors++; $display("FAIL rel_in_ready_early: got %b want 0", sif.in_ready); end
      @(negedge clk);
      checks++;
      if (sif.in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready: got %b want 1", sif.in_ready); end
      checks++;
      if (dut.u_lfsr.r_lfsr !== 16'h5670) begin errors++; $display("FAIL lfsr_step1: got %h want 5670", dut.u_lfsr.r_lfsr); end
   endtask

   task automatic test_seed_one();
      int nv, sb, hb, nr, lc; bit r, hung; logic [1:0] si, sj; logic sr;
      sif.seed_load = 1'b1; sif.seed = 16'h0001;
      @(negedge clk);
      sif.seed_load = 1'b0;
      checks++;
      if (dut.u_lfsr.r_lfsr !== 16'h0001) begin errors++; $display("FAIL seed1_lfsr: got %h want 0001", dut.u_lfsr.r_lfsr); end
      run_txn(1'b1, 1'b1, 3, 1'b0, nv, r, sb, hb, nr, lc, si, sj, sr, hung);
      checks++;
      if (hung !== 1'b0) begin errors++; $display("FAIL seed1_hung: got %b want 0", hung); end
      checks++;
      if (si !== 2'b01 || sj !== 2'b01 || sr !== 1'b0) begin
         errors++; $display("FAIL seed1_shares: ina=%b inb=%b rin=%b want 01 01 0", si, sj, sr);
      end
      checks++;
      if (nv !== 1 || r !== 1'b1) begin errors++; $display("FAIL seed1_res: pulses=%0d res=%b want 1 1", nv, r); end
      checks++;
      if (lc !== 6 || nr !== 3) begin errors++; $display("FAIL seed1_latency: lat=%0d run=%0d want 6 3", lc, nr); end
      checks++;
      if (sb !== 0 || hb !== 0) begin errors++; $display("FAIL seed1_share_hold: share_bad=%0d hold_bad=%0d want 0 0", sb, hb); end
   endtask

   task automatic test_seed_collision();
      int w;
      bit seen;
      sif.seed_load = 1'b1; sif.seed = 16'h0001;
      @(negedge clk);
      sif.seed_load = 1'b0;
      done_lat = 1; sif.a_in = 1'b1; sif.b_in = 1'b0; sif.in_valid = 1'b1;
      @(negedge clk);
      sif.in_valid = 1'b0;
      sif.seed_load = 1'b1; sif.seed = 16'h0007;
      @(negedge clk);
      sif.seed_load = 1'b0;
      checks++;
      if (sif.and_enable !== 1'b1 || sif.ina !== 2'b01 || sif.inb !== 2'b00 || sif.rin !== 1'b0) begin
         errors++;
         $display("FAIL collide_shares: en=%b ina=%b inb=%b rin=%b want 1 01 00 0", sif.and_enable, sif.ina, sif.inb, sif.rin);
      end
      checks++;
      if (dut.u_lfsr.r_lfsr !== 16'h0007) begin errors++; $display("FAIL collide_lfsr: got %h want 0007", dut.u_lfsr.r_lfsr); end
      seen = 1'b0; w = 0;
      while (sif.in_ready !== 1'b1 && w < 20) begin
         @(negedge clk);
         if (sif.res_valid === 1'b1) begin
            seen = 1'b1;
            checks++;
            if (sif.res !== 1'b0) begin errors++; $display("FAIL collide_res: got %b want 0", sif.res); end
         end
         w++;
      end
      checks++;
      if (seen !== 1'b1 || sif.in_ready !== 1'b1) begin errors++; $display("FAIL collide_done: seen=%b ready=%b want 1 1", seen, sif.in_ready); end
   endtask

   task automatic test_random_seeds();
      int nv, sb, hb, nr, lc; bit r, hung; logic [1:0] si, sj; logic sr;
      bit a, b;
      for (int s = 0; s < 64; s++) begin
         for (int ab = 0; ab < 4; ab++) begin
            a = ab[1]; b = ab[0];
            sif.seed_load = 1'b1; sif.seed = 16'($urandom);
            @(negedge clk);
            sif.seed_load = 1'b0;
            run_txn(a, b, 1 + ((s + ab) % 4), 1'b0, nv, r, sb, hb, nr, lc, si, sj, sr, hung);
            checks++;
            if (hung !== 1'b0 || nv !== 1) begin
               errors++; $display("FAIL rand_pulse s=%0d ab=%0d: hung=%b pulses=%0d want 0 1", s, ab, hung, nv);
            end
            checks++;
            if (r !== (a & b)) begin errors++; $display("FAIL rand_res s=%0d ab=%0d: got %b want %b", s, ab, r, a & b); end
            checks++;
            if (sb !== 0 || hb !== 0) begin
               errors++; $display("FAIL rand_shares s=%0d ab=%0d: share_bad=%0d hold_bad=%0d want 0 0", s, ab, sb, hb);
            end
         end
      end
   endtask

   task automatic test_timeout();
      int nv, sb, hb, nr, lc; bit r, hung; logic [1:0] si, sj; logic sr;
      checks++;
      if (sif.err_timeout !== 1'b0) begin errors++; $display("FAIL to_pre_err: got %b want 0", sif.err_timeout); end
      run_txn(1'b1, 1'b1, 0, 1'b0, nv, r, sb, hb, nr, lc, si, sj, sr, hung);
      checks++;
      if (hung !== 1'b0 || nr !== 8) begin errors++; $display("FAIL to_run_cycles: hung=%b run=%0d want 0 8", hung, nr); end
      checks++;
      if (nv !== 0) begin errors++; $display("FAIL to_no_valid: got %0d pulses want 0", nv); end
      checks++;
      if (sif.err_timeout !== 1'b1 || sif.and_enable !== 1'b0 || sif.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL to_flags: err=%b en=%b ready=%b want 1 0 1", sif.err_timeout, sif.and_enable, sif.in_ready);
      end
      run_txn(1'b0, 1'b1, 2, 1'b0, nv, r, sb, hb, nr, lc, si, sj, sr, hung);
      checks++;
      if (nv !== 1 || r !== 1'b0) begin errors++; $display("FAIL to_after_res: pulses=%0d res=%b want 1 0", nv, r); end
      checks++;
      if (sif.err_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", sif.err_timeout); end
   endtask

   task automatic test_spurious_done();
      spur_done = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (sif.res_valid !== 1'b0 || sif.res !== 1'b0 || sif.in_ready !== 1'b1 || sif.and_enable !== 1'b0) begin
            errors++;
            $display("FAIL spur_done_%0d: rv=%b res=%b ready=%b en=%b want 0 0 1 0", i, sif.res_valid, sif.res, sif.in_ready, sif.and_enable);
         end
      end
      spur_done = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int w;
      int nv, sb, hb, nr, lc; bit r, hung; logic [1:0] si, sj; logic sr;
      done_lat = 0; sif.a_in = 1'b1; sif.b_in = 1'b1; sif.in_valid = 1'b1;
      @(negedge clk);
      sif.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (sif.and_enable !== 1'b1) begin errors++; $display("FAIL rmid_pre_en: got %b want 1", sif.and_enable); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (sif.and_enable !== 1'b0 || sif.res_valid !== 1'b0 || sif.ina !== 2'b00) begin
         errors++; $display("FAIL rmid_async: en=%b rv=%b ina=%b want 0 0 00", sif.and_enable, sif.res_valid, sif.ina);
      end
      checks++;
      if (sif.err_timeout !== 1'b0) begin errors++; $display("FAIL rmid_err_clr: got %b want 0", sif.err_timeout); end
      @(negedge clk);
      rst_n = 1'b1;
      w = 0;
      while (sif.in_ready !== 1'b1 && w < 5) begin
         @(negedge clk);
         checks++;
         if (sif.res_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_valid: got %b want 0", sif.res_valid); end
         w++;
      end
      run_txn(1'b1, 1'b0, 2, 1'b0, nv, r, sb, hb, nr, lc, si, sj, sr, hung);
      checks++;
      if (hung !== 1'b0 || nv !== 1 || r !== 1'b0) begin
         errors++; $display("FAIL rmid_fresh: hung=%b pulses=%0d res=%b want 0 1 0", hung, nv, r);
      end
   endtask

   task automatic test_back_to_back();
      bit ta [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      bit tb [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      bit te [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int nv, sb, hb, nr, lc; bit r, hung; logic [1:0] si, sj; logic sr;
      int accepts = 0;
      int extra = 0;
      for (int i = 0; i < 4; i++) begin
         run_txn(ta[i], tb[i], 1 + i, 1'b1, nv, r, sb, hb, nr, lc, si, sj, sr, hung);
         if (!hung) accepts++;
         checks++;
         if (nv !== 1 || r !== te[i]) begin errors++; $display("FAIL b2b_res_%0d: pulses=%0d res=%b want 1 %b", i, nv, r, te[i]); end
         checks++;
         if (sb !== 0 || hb !== 0 || nr !== 1 + i) begin
            errors++; $display("FAIL b2b_hold_%0d: share_bad=%0d hold_bad=%0d run=%0d want 0 0 %0d", i, sb, hb, nr, 1 + i);
         end
      end
      sif.in_valid = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (sif.res_valid !== 1'b0 || sif.in_ready !== 1'b1) extra++;
      end
      checks++;
      if (accepts !== 4 || extra !== 0) begin errors++; $display("FAIL b2b_count: accepts=%0d extra=%0d want 4 0", accepts, extra); end
   endtask

   task automatic test_lfsr_period();
      int zeros = 0;
      int first_ret = 0;
      sif.seed_load = 1'b1; sif.seed = 16'h0000;
      @(negedge clk);
      sif.seed_load = 1'b0;
      checks++;
      if (dut.u_lfsr.r_lfsr !== 16'h0001) begin errors++; $display("FAIL seed0_lfsr: got %h want 0001", dut.u_lfsr.r_lfsr); end
      for (int n = 1; n <= 70000; n++) begin
         @(negedge clk);
         if (dut.u_lfsr.r_lfsr == 16'h0000) zeros++;
         if (dut.u_lfsr.r_lfsr == 16'h0001 && first_ret == 0) first_ret = n;
      end
      checks++;
      if (zeros !== 0) begin errors++; $display("FAIL lfsr_zero: got %0d zero cycles want 0", zeros); end
      checks++;
      if (first_ret !== 65535) begin errors++; $display("FAIL lfsr_period: got %0d want 65535", first_ret); end
   endtask

   initial begin
      test_reset();
      test_seed_one();
      test_seed_collision();
      test_random_seeds();
      test_timeout();
      test_spurious_done();
      test_reset_mid();
      test_back_to_back();
      test_lfsr_period();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
